// File: rtl/digit_joiner.sv
// Keypad operand assembler: builds a 15-bit sign-magnitude operand from BCD keys, converting one digit per clock on commit.
// Optional backspace key is enabled by defining DIGIT_JOINER_BACKSPACE_EN.
module digit_joiner #(
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        commit,
  input  logic        clear,
`ifdef DIGIT_JOINER_BACKSPACE_EN
  input  logic        del_key,
`endif
  output logic [15:0] entry_bcd,
  output logic [2:0]  entry_count,
  output logic        entry_neg,
  output logic        busy,
  output logic [14:0] result,
  output logic        result_valid,
  output logic        key_error
);

  typedef enum logic [1:0] {IDLE, ENTRY, CONVERT, DONE} state_t;

  localparam logic [2:0] LIMIT_POS = 3'(MAX_DIGITS);
  localparam logic [2:0] LAST_CYC  = 3'(MAX_DIGITS - 1);

  state_t      state_q;
  logic [15:0] entry_bcd_q;
  logic [2:0]  entry_count_q;
  logic        entry_neg_q;
  logic [15:0] shift_q;
  logic [13:0] acc_q;
  logic [2:0]  cyc_q;
  logic [14:0] result_q;
  logic        result_valid_q;
  logic        key_error_q;

  logic [2:0]  limit_d;
  logic [3:0]  top_digit_d;
  logic [13:0] acc_d;

  // A negative entry gives up one digit to the sign on the display.
  assign limit_d     = entry_neg_q ? LIMIT_POS - 3'd1 : LIMIT_POS;
  assign top_digit_d = shift_q[4*MAX_DIGITS-1 -: 4];
  assign acc_d       = acc_q * 14'd10 + {10'd0, top_digit_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      entry_bcd_q    <= '0;
      entry_count_q  <= '0;
      entry_neg_q    <= 1'b0;
      shift_q        <= '0;
      acc_q          <= '0;
      cyc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      key_error_q    <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      key_error_q    <= 1'b0;
      case (state_q)
        IDLE, ENTRY: begin
          if (clear) begin
            entry_bcd_q   <= '0;
            entry_count_q <= '0;
            entry_neg_q   <= 1'b0;
            state_q       <= IDLE;
          end else if (commit) begin
            acc_q   <= '0;
            shift_q <= entry_bcd_q;
            cyc_q   <= '0;
            state_q <= CONVERT;
`ifdef DIGIT_JOINER_BACKSPACE_EN
          end else if (del_key) begin
            if (state_q == IDLE) begin
              key_error_q <= 1'b1;
            end else if (entry_count_q != 3'd0) begin
              entry_bcd_q   <= {4'd0, entry_bcd_q[15:4]};
              entry_count_q <= entry_count_q - 3'd1;
              if (entry_count_q == 3'd1 && !entry_neg_q) state_q <= IDLE;
            end else begin
              entry_neg_q <= 1'b0;
              state_q     <= IDLE;
            end
`endif
          end else if (key_valid) begin
            if (key_code <= 4'd9) begin
              if (entry_count_q < limit_d) begin
                entry_bcd_q   <= {entry_bcd_q[11:0], key_code};
                entry_count_q <= entry_count_q + 3'd1;
                state_q       <= ENTRY;
              end else begin
                key_error_q <= 1'b1;
              end
            end else if (key_code == 4'd10 && entry_count_q == 3'd0 && !entry_neg_q) begin
              entry_neg_q <= 1'b1;
              state_q     <= ENTRY;
            end else begin
              key_error_q <= 1'b1;
            end
          end
        end
        CONVERT: begin
          if (clear) begin
            entry_bcd_q   <= '0;
            entry_count_q <= '0;
            entry_neg_q   <= 1'b0;
            state_q       <= IDLE;
          end else begin
            acc_q   <= acc_d;
            shift_q <= {shift_q[11:0], 4'd0};
            cyc_q   <= cyc_q + 3'd1;
            // Publish on the final digit so the result lands with the DONE state.
            if (cyc_q == LAST_CYC) begin
              result_q       <= {entry_neg_q & (acc_d != 14'd0), acc_d};
              result_valid_q <= 1'b1;
              state_q        <= DONE;
            end
          end
        end
        default: begin
          entry_bcd_q   <= '0;
          entry_count_q <= '0;
          entry_neg_q   <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign entry_bcd    = entry_bcd_q;
  assign entry_count  = entry_count_q;
  assign entry_neg    = entry_neg_q;
  assign busy         = (state_q == CONVERT);
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign key_error    = key_error_q;

endmodule

// File: tb/tb_digit_joiner.sv
// Randomised bench for digit_joiner: a digit-list reference model feeds a result scoreboard checked by a monitor.
module tb_digit_joiner;
  localparam int MD = 4;

  logic        clk = 1'b0;
  logic        rst, key_valid, commit, clear;
  logic [3:0]  key_code;
`ifdef DIGIT_JOINER_BACKSPACE_EN
  logic        del_key = 1'b0;
`endif
  logic [15:0] entry_bcd;
  logic [2:0]  entry_count;
  logic        entry_neg, busy, result_valid, key_error;
  logic [14:0] result;

  always #5 clk = ~clk;

  digit_joiner #(.MAX_DIGITS(MD)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .commit(commit), .clear(clear),
`ifdef DIGIT_JOINER_BACKSPACE_EN
    .del_key(del_key),
`endif
    .entry_bcd(entry_bcd), .entry_count(entry_count), .entry_neg(entry_neg),
    .busy(busy), .result(result), .result_valid(result_valid), .key_error(key_error)
  );

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q[$];
  logic [14:0] last_res = '0;
  int digits[$];
  bit neg = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_val();
    int v = 0;
    foreach (digits[i]) v = v * 10 + digits[i];
    return v;
  endfunction

  function automatic int model_bcd();
    int v = 0;
    foreach (digits[i]) v = v * 16 + digits[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every result_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && result_valid) begin
      if (exp_q.size() == 0) chk("unexpected_result_valid", 1, 0);
      else chk("result_pulse", int'(result), int'(exp_q.pop_front()));
    end
  end

  task automatic check_entry(input string tag);
    chk({tag, "_bcd"}, int'(entry_bcd), model_bcd());
    chk({tag, "_count"}, int'(entry_count), digits.size());
    chk({tag, "_neg"}, int'(entry_neg), int'(neg));
  endtask

  task automatic press(input logic [3:0] c);
    bit exp_err;
    int limit = neg ? MD - 1 : MD;
    exp_err = 1'b0;
    if (c <= 4'd9) begin
      if (digits.size() < limit) digits.push_back(int'(c));
      else exp_err = 1'b1;
    end else if (c == 4'd10 && digits.size() == 0 && !neg) begin
      neg = 1;
    end else begin
      exp_err = 1'b1;
    end
    key_valid = 1'b1;
    key_code  = c;
    tick();
    key_valid = 1'b0;
    chk("key_error", int'(key_error), int'(exp_err));
    check_entry("press");
  endtask

  task automatic clear_op();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    digits.delete();
    neg = 0;
    check_entry("clear");
    chk("clear_result_hold", int'(result), int'(last_res));
  endtask

  // abort_at=k asserts clear during the k-th busy cycle; 0 runs to completion.
  task automatic commit_op(input int abort_at, input bit with_key);
    int v;
    logic [14:0] e;
    v = model_val();
    e = (neg && v != 0) ? (15'h4000 | 15'(v)) : 15'(v);
    if (abort_at == 0) exp_q.push_back(e);
    commit = 1'b1;
    if (with_key) begin
      key_valid = 1'b1;
      key_code  = 4'($urandom_range(0, 9));
    end
    tick();
    commit    = 1'b0;
    key_valid = 1'b0;
    chk("commit_key_error", int'(key_error), 0);
    for (int i = 0; i < MD; i++) begin
      chk("busy_high", int'(busy), 1);
      check_entry("frozen");
      if (abort_at == i + 1) begin
        clear = 1'b1;
        tick();
        clear = 1'b0;
        digits.delete();
        neg = 0;
        chk("abort_busy", int'(busy), 0);
        check_entry("abort");
        chk("abort_result_hold", int'(result), int'(last_res));
        return;
      end
      key_valid = 1'($urandom_range(0, 1));
      key_code  = 4'($urandom);
      tick();
      key_valid = 1'b0;
      chk("convert_key_error", int'(key_error), 0);
    end
    chk("done_busy", int'(busy), 0);
    chk("done_result", int'(result), int'(e));
    last_res = e;
    tick();
    digits.delete();
    neg = 0;
    chk("idle_busy", int'(busy), 0);
    check_entry("post_done");
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 4'd0; commit = 1'b0; clear = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_key_error", int'(key_error), 0);
    check_entry("rst");

    press(1); press(2); press(3); press(4);
    commit_op(0, 0);
    press(10); press(5); press(0); press(7);
    commit_op(0, 0);
    press(10); press(1); press(2); press(3); press(4);
    commit_op(0, 0);
    press(12); press(3); press(10);
    clear_op();
    press(10);
    commit_op(0, 0);
    commit_op(0, 0);
    press(9); press(9);
    commit_op(2, 0);
    press(6);
    commit_op(0, 1);

    for (int n = 0; n < 80; n++) begin
      int r = $urandom_range(0, 9);
      if (r <= 5) begin
        if ($urandom_range(0, 3) == 0) press(4'($urandom_range(10, 15)));
        else press(4'($urandom_range(0, 9)));
      end else if (r <= 7) commit_op(0, 1'($urandom_range(0, 1)));
      else if (r == 8) clear_op();
      else commit_op($urandom_range(1, MD), 0);
    end

    tick();
    tick();
    chk("pending_results", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
